binoc_lp_chan_ctrl: RTL and testbench

Low-priority (LP) end controller for one bidirectional inter-router channel of the BiNoC mesh. It is the counterpart of the high-priority (HP) end, which owns the channel after reset. The block buffers outgoing flits from the local router output port and requests channel ownership from the HP end. After the grant and a turnaround cycle it drives the shared bus, then hands ownership back after a packet tail. While not owning the channel, it receives flits from the HP end and forwards them to the router input port.

---
 rtl/binoc_pkg.sv | 38 +++
 rtl/binoc_lp_chan_ctrl_if.sv | 24 ++
 rtl/binoc_flit_fifo.sv | 54 +++++
 rtl/binoc_lp_chan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_binoc_lp_chan_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/binoc_pkg.sv
// Shared types for the BiNoC LP channel controller: flit layout, FSM states,
// channel control bit indices (parity bit only with BINOC_CHAN_PARITY_EN).
package binoc_pkg;

  localparam int FLIT_W_DEF = 32;

  localparam int CTL_VALID = 0;
  localparam int CTL_TAIL  = 1;
`ifdef BINOC_CHAN_PARITY_EN
  localparam int CTL_PAR   = 2;
  localparam int CTL_W     = 3;
`else
  localparam int CTL_W     = 2;
`endif

  typedef enum logic [2:0] {
    IN,
    REQ,
    TURN,
    OUT,
    REL
  } chan_state_e;

  typedef struct packed {
    logic                  tail;
    logic [FLIT_W_DEF-1:0] data;
  } flit_t;

  // Even parity bit covering data, tail and valid.
  function automatic logic even_par(
    input logic [FLIT_W_DEF-1:0] d,
    input logic                  t,
    input logic                  v
  );
    return ^{d, t, v};
  endfunction

endpackage

// File: rtl/binoc_lp_chan_ctrl_if.sv
// Router-side port bundle of the LP channel end: tx flit handshake (router -> LP)
// and rx flit delivery (LP -> router). master = router, slave = controller.
interface binoc_lp_chan_ctrl_if #(
  parameter int FLIT_W = binoc_pkg::FLIT_W_DEF
);
  logic              tx_valid_i;
  logic [FLIT_W-1:0] tx_flit_i;
  logic              tx_tail_i;
  logic              tx_ready_o;
  logic              rx_valid_o;
  logic [FLIT_W-1:0] rx_flit_o;
  logic              rx_tail_o;
  logic              rx_full_i;

  modport master (
    output tx_valid_i, tx_flit_i, tx_tail_i, rx_full_i,
    input  tx_ready_o, rx_valid_o, rx_flit_o, rx_tail_o
  );

  modport slave (
    input  tx_valid_i, tx_flit_i, tx_tail_i, rx_full_i,
    output tx_ready_o, rx_valid_o, rx_flit_o, rx_tail_o
  );
endinterface

// File: rtl/binoc_flit_fifo.sv
// Synchronous flit FIFO, async active-high reset. Ports: push_i/din_i,
// pop_i/dout_o (head, show-ahead), full_o, empty_o, count_o (occupancy).
module binoc_flit_fifo
  import binoc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = flit_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  T            din_i,
  input  logic        pop_i,
  output T            dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  T mem_q [DEPTH];

  // Pointers carry one wrap bit to tell full from empty.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/binoc_lp_chan_ctrl.sv
// LP end of a BiNoC bidirectional channel: buffers router tx flits, requests
// the bus from HP, drives it after a turnaround, hands it back after a tail,
// and forwards HP flits to the router while not owning the bus.
// Ports: clk/rst, rtr (router bundle), req_o/gnt_i/peer_req_i/gnt_o ownership,
// full_i/full_o backpressure, chan_data_io/chan_ctl_io shared bus,
// parity_err_o (sticky; live only with BINOC_CHAN_PARITY_EN).
module binoc_lp_chan_ctrl
  import binoc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  binoc_lp_chan_ctrl_if.slave rtr,
  output logic               req_o,
  input  logic               gnt_i,
  input  logic               peer_req_i,
  output logic               gnt_o,
  input  logic               full_i,
  output logic               full_o,
  inout  wire  [FLIT_W-1:0]  chan_data_io,
  inout  wire  [CTL_W-1:0]   chan_ctl_io,
  output logic               parity_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  chan_state_e state_q, state_d;

  flit_t       head;
  flit_t       wr_flit;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_cnt;

  logic        push, pop, last_out;
  logic        drv_en, rx_en;
  logic        ready_en_q;

  logic [FLIT_W-1:0] tx_data;
  logic [FLIT_W-1:0] hold_q;
  logic [CTL_W-1:0]  tx_ctl;
  logic [FLIT_W-1:0] rx_data;
  logic [CTL_W-1:0]  rx_ctl;
  logic              rx_hit;

  logic              rx_valid_q;
  logic [FLIT_W-1:0] rx_flit_q;
  logic              rx_tail_q;
  logic              full_q;

  assign wr_flit = '{tail: rtr.tx_tail_i, data: rtr.tx_flit_i};

  binoc_flit_fifo #(
    .DEPTH(DEPTH),
    .T    (flit_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (wr_flit),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  // ready_en_q keeps tx_ready_o low during and just after reset.
  assign rtr.tx_ready_o = ready_en_q & ~fifo_full;
  assign push = rtr.tx_valid_i & rtr.tx_ready_o;
  assign pop  = (state_q == OUT) & ~fifo_empty & ~full_i;

  // A popped tail gives the bus back if HP wants it or nothing follows it.
  assign last_out = pop & head.tail &
                    (peer_req_i | ((fifo_cnt == CW'(1)) & ~push));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IN:      if (push | ~fifo_empty) state_d = REQ;
      REQ:     if (gnt_i) state_d = TURN;
      TURN:    state_d = OUT;
      OUT:     if (last_out) state_d = REL;
      REL:     state_d = IN;
      default: state_d = IN;
    endcase
  end

  always_comb begin
    req_o  = 1'b0;
    gnt_o  = 1'b0;
    drv_en = 1'b0;
    rx_en  = 1'b0;
    unique case (state_q)
      IN:      rx_en = 1'b1;
      REQ: begin
        req_o = 1'b1;
        rx_en = 1'b1;
      end
      TURN:    ;
      OUT:     drv_en = 1'b1;
      REL:     gnt_o = 1'b1;
      default: ;
    endcase
  end

  // Idle OUT cycles keep the last flit's data on the bus.
  assign tx_data = pop ? head.data : hold_q;

  always_comb begin
    tx_ctl = '0;
    tx_ctl[CTL_VALID] = pop;
    tx_ctl[CTL_TAIL]  = pop & head.tail;
`ifdef BINOC_CHAN_PARITY_EN
    tx_ctl[CTL_PAR]   = even_par(tx_data, tx_ctl[CTL_TAIL], pop);
`endif
  end

  assign chan_data_io = drv_en ? tx_data : 'z;
  assign chan_ctl_io  = drv_en ? tx_ctl  : 'z;

  assign rx_data = chan_data_io;
  assign rx_ctl  = chan_ctl_io;
  assign rx_hit  = rx_en & rx_ctl[CTL_VALID];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      hold_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_flit_q  <= '0;
      rx_tail_q  <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (pop) hold_q <= head.data;
      rx_valid_q <= rx_hit;
      if (rx_hit) begin
        rx_flit_q <= rx_data;
        rx_tail_q <= rx_ctl[CTL_TAIL];
      end
      full_q <= rtr.rx_full_i;
    end
  end

`ifdef BINOC_CHAN_PARITY_EN
  logic par_err_q;

  // Bad flits are still delivered; the error only latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      par_err_q <= 1'b0;
    else if (rx_hit & ^{rx_data, rx_ctl}) par_err_q <= 1'b1;
  end

  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign rtr.rx_valid_o = rx_valid_q;
  assign rtr.rx_flit_o  = rx_flit_q;
  assign rtr.rx_tail_o  = rx_tail_q;
  assign full_o         = full_q;

endmodule

// File: tb/tb_binoc_lp_chan_ctrl.sv
// Bench for binoc_lp_chan_ctrl: rx vector table, directed ownership sequences,
// randomized traffic against a queue/ownership reference model.
`timescale 1ns/1ps
module tb_binoc_lp_chan_ctrl;
  import binoc_pkg::*;

  localparam int W     = FLIT_W_DEF;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  binoc_lp_chan_ctrl_if #(.FLIT_W(W)) rtr ();

  logic req_o, gnt_i, peer_req_i, gnt_o;
  logic full_i, full_o, parity_err_o;

  wire  [W-1:0]     chan_data;
  wire  [CTL_W-1:0] chan_ctl;
  logic             hp_drv;
  logic [W-1:0]     hp_data;
  logic [CTL_W-1:0] hp_ctl;

  assign chan_data = hp_drv ? hp_data : 'z;
  assign chan_ctl  = hp_drv ? hp_ctl  : 'z;

  binoc_lp_chan_ctrl #(.FLIT_W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rtr         (rtr),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .peer_req_i  (peer_req_i),
    .gnt_o       (gnt_o),
    .full_i      (full_i),
    .full_o      (full_o),
    .chan_data_io(chan_data),
    .chan_ctl_io (chan_ctl),
    .parity_err_o(parity_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic bus_v();
    return chan_ctl[CTL_VALID] === 1'b1;
  endfunction

  function automatic logic [CTL_W-1:0] mk_ctl(input logic [W-1:0] d,
    input logic t, input logic v, input logic bad);
    logic [CTL_W-1:0] c;
    c = '0;
    c[CTL_VALID] = v;
    c[CTL_TAIL]  = t;
`ifdef BINOC_CHAN_PARITY_EN
    c[CTL_PAR]   = (^{d, t, v}) ^ bad;
`endif
    return c;
  endfunction

  task automatic push1(input logic [W-1:0] d, input logic t);
    int n;
    n = 0;
    rtr.tx_valid_i = 1'b1;
    rtr.tx_flit_i  = d;
    rtr.tx_tail_i  = t;
    #1;
    while (!rtr.tx_ready_o && n < 10) begin
      tick(); #1; n++;
    end
    chk("tx_ready", rtr.tx_ready_o, 1);
    tick();
    rtr.tx_valid_i = 1'b0;
  endtask

  task automatic grant();
    int n;
    n = 0;
    #1;
    while (!req_o && n < 10) begin
      tick(); #1; n++;
    end
    chk("req_wait", req_o, 1);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    #1;
    chk("turn_req", req_o, 0);
    chk("turn_idle", bus_v(), 0);
    tick();
  endtask

  task automatic expect_out(input logic [W-1:0] d, input logic t);
    #1;
    chk("out_valid", bus_v(), 1);
    chk("out_data", chan_data, d);
    chk("out_tail", chan_ctl[CTL_TAIL], t);
    chk("out_gnt", gnt_o, 0);
    tick();
  endtask

  task automatic expect_rel();
    #1;
    chk("rel_gnt", gnt_o, 1);
    chk("rel_idle", bus_v(), 0);
    tick();
    #1;
    chk("rel_pulse", gnt_o, 0);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         t;
    logic         rf;
    logic         ev;
    logic [W-1:0] ed;
    logic         et;
    logic         ef;
  } rxvec_t;

  rxvec_t tbl[6];

  flit_t        mq[$];
  bit           owned, rel_exp, need_tail;
  bit           hp_pv, hp_pt, prev_rf;
  logic [W-1:0] hp_pd;

  task automatic step(input bit drain);
    bit    push, lpv, rel_n, gnt, hv, ht;
    flit_t f;
    if (drain) begin
      rtr.tx_valid_i = need_tail;
      rtr.tx_tail_i  = 1'b1;
      rtr.tx_flit_i  = $urandom;
      full_i         = 1'b0;
      peer_req_i     = 1'b0;
      rtr.rx_full_i  = 1'b0;
    end else begin
      rtr.tx_valid_i = 1'($urandom_range(0, 1));
      rtr.tx_tail_i  = ($urandom_range(0, 2) == 0);
      rtr.tx_flit_i  = $urandom;
      full_i         = ($urandom_range(0, 3) == 0);
      peer_req_i     = ($urandom_range(0, 3) == 0);
      rtr.rx_full_i  = 1'($urandom_range(0, 1));
    end
    gnt = 1'b0;
    if (!owned) begin
      if (req_o) gnt = drain || ($urandom_range(0, 2) == 0);
      else       gnt = ($urandom_range(0, 7) == 0);
    end
    gnt_i   = gnt;
    hv      = 1'($urandom_range(0, 1));
    ht      = 1'($urandom_range(0, 1));
    hp_drv  = !owned && !gnt && !drain && ($urandom_range(0, 2) == 0);
    hp_data = $urandom;
    hp_ctl  = mk_ctl(hp_data, ht, hv, 1'b0);
    #1;
    chk("r_ready", rtr.tx_ready_o, (mq.size() < DEPTH));
    chk("r_gnt_o", gnt_o, rel_exp);
    chk("r_full_o", full_o, prev_rf);
    chk("r_rx_valid", rtr.rx_valid_o, hp_pv);
    if (hp_pv) begin
      chk("r_rx_data", rtr.rx_flit_o, hp_pd);
      chk("r_rx_tail", rtr.rx_tail_o, hp_pt);
    end
    if (owned) chk("r_req_owned", req_o, 0);
    if (!owned && !hp_drv) chk("r_bus_idle", bus_v(), 0);
    lpv   = owned && bus_v();
    rel_n = 1'b0;
    push  = rtr.tx_valid_i && rtr.tx_ready_o;
    if (lpv) begin
      chk("r_full_block", full_i, 0);
      if (mq.size() == 0) begin
        chk("r_extra_flit", bus_v(), 0);
      end else begin
        f = mq.pop_front();
        chk("r_tx_data", chan_data, f.data);
        chk("r_tx_tail", chan_ctl[CTL_TAIL], f.tail);
        rel_n = f.tail && (peer_req_i || (mq.size() == 0 && !push));
      end
    end
    if (push) begin
      mq.push_back('{tail: rtr.tx_tail_i, data: rtr.tx_flit_i});
      need_tail = !rtr.tx_tail_i;
    end
    if (gnt && req_o) owned = 1'b1;
    else if (rel_exp) owned = 1'b0;
    hp_pv   = hp_drv && hv;
    hp_pd   = hp_data;
    hp_pt   = ht;
    prev_rf = rtr.rx_full_i;
    rel_exp = rel_n;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rtr.tx_valid_i = 1'b0;
    rtr.tx_flit_i  = '0;
    rtr.tx_tail_i  = 1'b0;
    rtr.rx_full_i  = 1'b0;
    gnt_i      = 1'b0;
    peer_req_i = 1'b0;
    full_i     = 1'b0;
    hp_drv     = 1'b0;
    hp_data    = '0;
    hp_ctl     = '0;

    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 32'hFF, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", rtr.tx_ready_o, 0);
    chk("rst_req", req_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rx_valid", rtr.rx_valid_o, 0);
    chk("rst_full_o", full_o, 0);
    chk("rst_par", parity_err_o, 0);
    chk("rst_bus", bus_v(), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_ready", rtr.tx_ready_o, 1);

    for (int i = 0; i < 6; i++) begin
      hp_drv        = 1'b1;
      hp_data       = tbl[i].d;
      hp_ctl        = mk_ctl(tbl[i].d, tbl[i].t, tbl[i].v, 1'b0);
      rtr.rx_full_i = tbl[i].rf;
      #1;
      chk("tbl_bus_hp", chan_data, tbl[i].d);
      tick();
      hp_drv = 1'b0;
      #1;
      chk("tbl_rx_valid", rtr.rx_valid_o, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_rx_data", rtr.rx_flit_o, tbl[i].ed);
        chk("tbl_rx_tail", rtr.rx_tail_o, tbl[i].et);
      end
      chk("tbl_full_o", full_o, tbl[i].ef);
      chk("tbl_req", req_o, 0);
    end
    rtr.rx_full_i = 1'b0;
    tick();
    #1;
    chk("rx_one_cycle", rtr.rx_valid_o, 0);
    chk("par_clean", parity_err_o, 0);

    // single packet A1, A2(tail)
    push1(32'hA1, 1'b0);
    #1;
    chk("req_next", req_o, 1);
    push1(32'hA2, 1'b1);
    grant();
    expect_out(32'hA1, 1'b0);
    expect_out(32'hA2, 1'b1);
    expect_rel();
    chk("back_in_req", req_o, 0);
    tick();

    // two packets, one ownership
    push1(32'hB1, 1'b1);
    push1(32'hC1, 1'b1);
    grant();
    expect_out(32'hB1, 1'b1);
    expect_out(32'hC1, 1'b1);
    expect_rel();
    tick();

    // peer_req forces release after first packet
    push1(32'hB1, 1'b1);
    push1(32'hC1, 1'b1);
    peer_req_i = 1'b1;
    grant();
    expect_out(32'hB1, 1'b1);
    peer_req_i = 1'b0;
    expect_rel();
    grant();
    expect_out(32'hC1, 1'b1);
    expect_rel();
    tick();

    // full_i stall
    push1(32'hD1, 1'b0);
    push1(32'hD2, 1'b0);
    push1(32'hD3, 1'b1);
    grant();
    expect_out(32'hD1, 1'b0);
    full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", bus_v(), 0);
      chk("stall_hold", chan_data, 32'hD1);
      tick();
    end
    full_i = 1'b0;
    expect_out(32'hD2, 1'b0);
    expect_out(32'hD3, 1'b1);
    expect_rel();
    tick();

    // reset mid-packet
    push1(32'hE1, 1'b0);
    push1(32'hE2, 1'b0);
    grant();
    expect_out(32'hE1, 1'b0);
    #1;
    chk("mid_pkt_drv", bus_v(), 1);
    rst = 1'b1;
    #1;
    chk("arst_bus", bus_v(), 0);
    chk("arst_req", req_o, 0);
    chk("arst_gnt", gnt_o, 0);
    chk("arst_ready", rtr.tx_ready_o, 0);
    chk("arst_rx_valid", rtr.rx_valid_o, 0);
    chk("arst_rx_flit", rtr.rx_flit_o, 0);
    chk("arst_full_o", full_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    chk("arst_in_req", req_o, 0);
    chk("arst_in_bus", bus_v(), 0);
    chk("arst_in_ready", rtr.tx_ready_o, 1);
    tick();
    #1;
    chk("arst_fifo_empty", req_o, 0);

`ifdef BINOC_CHAN_PARITY_EN
    hp_drv  = 1'b1;
    hp_data = 32'h29;
    hp_ctl  = mk_ctl(32'h29, 1'b0, 1'b1, 1'b1);
    tick();
    hp_drv = 1'b0;
    #1;
    chk("par_rx_valid", rtr.rx_valid_o, 1);
    chk("par_rx_data", rtr.rx_flit_o, 32'h29);
    chk("par_err_set", parity_err_o, 1);
    hp_drv  = 1'b1;
    hp_data = 32'h30;
    hp_ctl  = mk_ctl(32'h30, 1'b1, 1'b1, 1'b0);
    tick();
    hp_drv = 1'b0;
    tick();
    #1;
    chk("par_err_hold", parity_err_o, 1);
    rst = 1'b1;
    #1;
    chk("par_err_clr", parity_err_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
`else
    chk("par_tied", parity_err_o, 0);
`endif

    owned     = 1'b0;
    rel_exp   = 1'b0;
    need_tail = 1'b0;
    hp_pv     = 1'b0;
    hp_pt     = 1'b0;
    hp_pd     = '0;
    prev_rf   = 1'b0;
    rtr.rx_full_i = 1'b0;
    tick();
    for (int i = 0; i < 3000; i++) step(1'b0);
    for (int i = 0; i < 300; i++) begin
      if (mq.size() == 0 && !owned && !rel_exp && !need_tail) break;
      step(1'b1);
    end
    chk("drain_left", mq.size(), 0);
    chk("drain_owned", owned, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
